// File: rtl/stb_trace_readout.sv
// Trace-buffer drain: after a trigger, reads every trace word oldest-first and streams it out LSB byte first.
// Optional 2-byte trigger header (event address, event bit position) enabled by defining STB_READOUT_HEADER_EN.
module stb_trace_readout #(
    parameter int TRB_WIDTH = 32,
    parameter int TRB_DEPTH = 64
) (
    input  logic                         CLK_I,
    input  logic                         RST_I,
    input  logic                         START_I,
    input  logic                         TRG_EVENT_I,
    input  logic [$clog2(TRB_DEPTH)-1:0] LAST_ADDR_I,
    input  logic [$clog2(TRB_DEPTH)-1:0] EVENT_ADDR_I,
    input  logic [$clog2(TRB_WIDTH)-1:0] EVENT_POS_I,
    output logic [$clog2(TRB_DEPTH)-1:0] READ_ADDR_O,
    input  logic [TRB_WIDTH-1:0]         DATA_I,
    output logic [7:0]                   TX_DATA_O,
    output logic                         TX_VALID_O,
    input  logic                         TX_READY_I,
    output logic                         BUSY_O,
    output logic                         DONE_O
);
    localparam int AW  = $clog2(TRB_DEPTH);
    localparam int PW  = $clog2(TRB_WIDTH);
    localparam int NB  = TRB_WIDTH / 8;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_LATCH, S_SEND, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]        word_cnt_q, word_cnt_d;
    logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
    logic [TRB_WIDTH-1:0] shift_q, shift_d;
    logic                 done_q, done_d;

`ifdef STB_READOUT_HEADER_EN
    logic                 hdr_sel_q, hdr_sel_d;
    logic [AW-1:0]        evt_addr_q, evt_addr_d;
    logic [PW-1:0]        evt_pos_q, evt_pos_d;
`else
    logic                 unused_evt;
    assign unused_evt = ^{EVENT_ADDR_I, EVENT_POS_I};
`endif

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            done_q     <= 1'b0;
`ifdef STB_READOUT_HEADER_EN
            hdr_sel_q  <= 1'b0;
            evt_addr_q <= '0;
            evt_pos_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
`ifdef STB_READOUT_HEADER_EN
            hdr_sel_q  <= hdr_sel_d;
            evt_addr_q <= evt_addr_d;
            evt_pos_q  <= evt_pos_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        done_d     = done_q;
`ifdef STB_READOUT_HEADER_EN
        hdr_sel_d  = hdr_sel_q;
        evt_addr_d = evt_addr_q;
        evt_pos_d  = evt_pos_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START_I && TRG_EVENT_I) begin
                    // Oldest word sits just after the last one written (circular buffer).
                    rd_ptr_d   = LAST_ADDR_I + 1'b1;
                    word_cnt_d = '0;
                    done_d     = 1'b0;
`ifdef STB_READOUT_HEADER_EN
                    hdr_sel_d  = 1'b0;
                    evt_addr_d = EVENT_ADDR_I;
                    evt_pos_d  = EVENT_POS_I;
                    state_d    = S_HDR;
`else
                    state_d    = S_FETCH;
`endif
                end
            end
`ifdef STB_READOUT_HEADER_EN
            S_HDR: begin
                if (TX_READY_I) begin
                    if (hdr_sel_q) state_d = S_FETCH;
                    else           hdr_sel_d = 1'b1;
                end
            end
`endif
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                shift_d    = DATA_I;
                byte_cnt_d = BCW'(NB - 1);
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (TX_READY_I) begin
                    shift_d = shift_q >> 8;
                    if (byte_cnt_q != '0) begin
                        byte_cnt_d = byte_cnt_q - 1'b1;
                    end else if (word_cnt_q == AW'(TRB_DEPTH - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Valid depends on state only, so ready never reaches valid combinationally.
    always_comb begin
        TX_DATA_O  = 8'h00;
        TX_VALID_O = 1'b0;
        if (state_q == S_SEND) begin
            TX_DATA_O  = shift_q[7:0];
            TX_VALID_O = 1'b1;
        end
`ifdef STB_READOUT_HEADER_EN
        if (state_q == S_HDR) begin
            TX_DATA_O  = hdr_sel_q ? 8'(evt_pos_q) : 8'(evt_addr_q);
            TX_VALID_O = 1'b1;
        end
`endif
    end

    assign READ_ADDR_O = rd_ptr_q;
    assign BUSY_O      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign DONE_O      = done_q;

endmodule

// File: tb/tb_stb_trace_readout.sv
// Directed bench for stb_trace_readout: order/wrap, trigger gating, backpressure, mid-run reset, start-while-busy.
module tb_stb_trace_readout;
`ifdef STB_READOUT_HEADER_EN
    localparam int H = 2;
`else
    localparam int H = 0;
`endif
    localparam int NDATA = 64 * 4;

    logic       CLK_I = 1'b0, RST_I = 1'b1, START_I = 1'b0, TRG_EVENT_I = 1'b0;
    logic [5:0] LAST_ADDR_I = '0, EVENT_ADDR_I = '0, READ_ADDR_O;
    logic [4:0] EVENT_POS_I = '0;
    logic [31:0] DATA_I = '0;
    logic [7:0] TX_DATA_O;
    logic       TX_VALID_O, TX_READY_I = 1'b1, BUSY_O, DONE_O;

    int checks = 0, errors = 0;
    int tot = 0, stall_err = 0;
    logic [7:0] blog [0:4095];
    bit   prev_stall = 0;
    logic [7:0] prev_data = '0;

    stb_trace_readout #(.TRB_WIDTH(32), .TRB_DEPTH(64)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .START_I(START_I), .TRG_EVENT_I(TRG_EVENT_I),
        .LAST_ADDR_I(LAST_ADDR_I), .EVENT_ADDR_I(EVENT_ADDR_I), .EVENT_POS_I(EVENT_POS_I),
        .READ_ADDR_O(READ_ADDR_O), .DATA_I(DATA_I), .TX_DATA_O(TX_DATA_O),
        .TX_VALID_O(TX_VALID_O), .TX_READY_I(TX_READY_I), .BUSY_O(BUSY_O), .DONE_O(DONE_O)
    );

    always #5 CLK_I = ~CLK_I;

    // Synchronous-read trace memory: word k holds A0B0C000+k.
    always @(posedge CLK_I) DATA_I <= 32'hA0B0C000 + {26'd0, READ_ADDR_O};

    always @(negedge CLK_I) begin
        if (RST_I) prev_stall = 0;
        else begin
            if (prev_stall && (!TX_VALID_O || TX_DATA_O !== prev_data)) stall_err++;
            if (TX_VALID_O && TX_READY_I && tot < 4096) begin
                blog[tot] = TX_DATA_O;
                tot++;
            end
            prev_stall = TX_VALID_O && !TX_READY_I;
            prev_data  = TX_DATA_O;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit bp);
        @(posedge CLK_I);
        #1;
        TX_READY_I = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic do_start();
        START_I = 1; TRG_EVENT_I = 1; LAST_ADDR_I = 6'd5; EVENT_ADDR_I = 6'd9; EVENT_POS_I = 5'd17;
        step(0);
        // Changes after the start edge must not affect the running readout.
        START_I = 0; TRG_EVENT_I = 0; LAST_ADDR_I = 6'd40; EVENT_ADDR_I = 6'd3; EVENT_POS_I = 5'd2;
    endtask

    task automatic run_readout(input bit bp, input int pulse_at);
        bit done = 0;
        for (int c = 0; c < 4000 && !done; c++) begin
            START_I     = (c == pulse_at);
            TRG_EVENT_I = (c == pulse_at);
            step(bp);
            if (DONE_O) done = 1;
        end
        START_I = 0; TRG_EVENT_I = 0; TX_READY_I = 1;
        chk("done_within_budget", 32'(done), 32'd1);
    endtask

    function automatic logic [7:0] exp_byte(input int j);
        int d;
        logic [5:0] a;
        logic [31:0] w;
        if (j < H) return (j == 0) ? 8'd9 : 8'd17;
        d = j - H;
        a = 6'((6 + d / 4) % 64);
        w = 32'hA0B0C000 + {26'd0, a};
        return 8'(w >> (8 * (d % 4)));
    endfunction

    task automatic check_bytes(input string tag, input int base, input int n);
        for (int j = 0; j < n; j++) chk(tag, 32'(blog[base + j]), 32'(exp_byte(j)));
    endtask

    initial begin
        int base;
        #12;
        chk("rst_read_addr", 32'(READ_ADDR_O), 0);
        chk("rst_tx_data", 32'(TX_DATA_O), 0);
        chk("rst_tx_valid", 32'(TX_VALID_O), 0);
        chk("rst_busy", 32'(BUSY_O), 0);
        chk("rst_done", 32'(DONE_O), 0);
        step(0);
        RST_I = 0;
        step(0);

        // START without trigger is ignored
        START_I = 1; TRG_EVENT_I = 0;
        step(0);
        START_I = 0;
        for (int i = 0; i < 3; i++) begin
            chk("gate_busy", 32'(BUSY_O), 0);
            chk("gate_valid", 32'(TX_VALID_O), 0);
            chk("gate_done", 32'(DONE_O), 0);
            step(0);
        end

        // Full readout, ready=1, with a second START pulsed mid-run
        base = tot;
        do_start();
        chk("start_busy", 32'(BUSY_O), 1);
        run_readout(0, 100);
        chk("run1_count", 32'(tot - base), 32'(H + NDATA));
        chk("run1_first_data", 32'(blog[base + H]), 32'h06);
        chk("run1_last_byte", 32'(blog[base + H + NDATA - 1]), 32'hA0);
        chk("run1_done_busy", 32'(BUSY_O), 0);
        check_bytes("run1_byte", base, H + NDATA);
        for (int i = 0; i < 3; i++) step(0);
        chk("done_sticky", 32'(DONE_O), 1);
        chk("idle_busy", 32'(BUSY_O), 0);

        // Ungated START leaves sticky DONE alone
        START_I = 1; TRG_EVENT_I = 0;
        step(0);
        START_I = 0;
        step(0);
        chk("gate_done_kept", 32'(DONE_O), 1);
        chk("gate_busy2", 32'(BUSY_O), 0);

        // Backpressure run
        base = tot;
        stall_err = 0;
        do_start();
        chk("start_clears_done", 32'(DONE_O), 0);
        run_readout(1, -1);
        chk("bp_count", 32'(tot - base), 32'(H + NDATA));
        chk("bp_stall_stable", 32'(stall_err), 0);
        check_bytes("bp_byte", base, H + NDATA);

        // Reset after 37 bytes
        step(0);
        base = tot;
        do_start();
        for (int c = 0; c < 2000 && (tot - base) < 37; c++) step(0);
        chk("pre_rst_count", 32'(tot - base), 37);
        #2 RST_I = 1;
        #1;
        chk("mid_rst_read_addr", 32'(READ_ADDR_O), 0);
        chk("mid_rst_tx_data", 32'(TX_DATA_O), 0);
        chk("mid_rst_tx_valid", 32'(TX_VALID_O), 0);
        chk("mid_rst_busy", 32'(BUSY_O), 0);
        chk("mid_rst_done", 32'(DONE_O), 0);
        step(0);
        RST_I = 0;
        step(0);
        base = tot;
        do_start();
        run_readout(0, -1);
        chk("restart_count", 32'(tot - base), 32'(H + NDATA));
        check_bytes("restart_byte", base, H + NDATA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
